// File: rtl/topsort_arb_pkg.sv
// Shared types and helpers for the round-robin registered arbiter.
// Holds the output-slot state encoding and the winner-index width rule.
package topsort_arb_pkg;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int arb_sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin search: first active request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module rr_grant #(
    parameter int N_REQ = 4,
    parameter int SW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SW-1:0]    ptr,
    output logic [SW-1:0]    gnt_idx,
    output logic             gnt_any
);

    // Walk offsets from farthest to nearest so the nearest active request
    // is the last assignment and therefore wins.
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop; a path that
        // leaves an always_comb output unassigned infers a latch.
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (req[idx]) begin
                gnt_idx = SW'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// N_REQ requesters share one output register; round-robin grant, one word
// per cycle when the downstream keeps i_ready high.
module rr_reg_arbiter
    import topsort_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int DW    = 32,
    localparam int SW    = arb_sel_width(N_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_valid,
    input  logic [N_REQ*DW-1:0] i_data,
    output logic [N_REQ-1:0]    o_ready,
    output logic                o_valid,
    output logic [DW-1:0]       o_data,
    output logic [SW-1:0]       o_src,
    input  logic                i_ready
);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] src_q, src_d;
    logic [DW-1:0] data_q, data_d;

    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic          can_load;
    logic          load;

    rr_grant #(
        .N_REQ (N_REQ),
        .SW    (SW)
    ) u_grant (
        .req     (i_valid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The slot accepts when empty or when its word leaves this same cycle.
    assign can_load = (state_q == ARB_EMPTY) || (i_ready && state_q == ARB_FULL);
    assign load     = can_load && gnt_any && !i_rst;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            o_ready[k] = load && (gnt_idx == SW'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        if (load) begin
            state_d = ARB_FULL;
            src_d   = gnt_idx;
            data_d  = i_data[gnt_idx*DW +: DW];
            ptr_d   = (gnt_idx == SW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == ARB_FULL && i_ready) begin
            state_d = ARB_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every flop reading the
        // pre-edge value of the others, whatever order the lines appear in.
        if (i_rst) begin
            state_q <= ARB_EMPTY;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = (state_q == ARB_FULL);
    assign o_data  = data_q;
    assign o_src   = src_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter: directed vectors push expected words,
// a monitor compares whatever the output register presents.
module tb_rr_reg_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 32;
    localparam int SW    = 2;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } exp_t;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic [N_REQ-1:0]    i_valid = '0;
    logic [N_REQ*DW-1:0] i_data = '0;
    logic [N_REQ-1:0]    o_ready;
    logic                o_valid;
    logic [DW-1:0]       o_data;
    logic [SW-1:0]       o_src;
    logic                i_ready = 1'b0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] tag = 8'h00;

    always #5 i_clk = ~i_clk;

    rr_reg_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_src   (o_src),
        .i_ready (i_ready)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [7:0] t, input int k);
        return {16'hA5A5, t, 8'(k)};
    endfunction

    function automatic int first_set(input logic [N_REQ-1:0] v);
        for (int k = 0; k < N_REQ; k++) if (v[k]) return k;
        return 0;
    endfunction

    // One directed cycle: drive, then check the combinational grant and slot
    // state before the edge; a hand-predicted grant becomes an expected word.
    task automatic step(input logic [N_REQ-1:0] v, input logic rdy,
                        input logic [N_REQ-1:0] exp_rdy, input logic exp_vld);
        int w;
        @(negedge i_clk);
        i_valid = v;
        i_ready = rdy;
        for (int k = 0; k < N_REQ; k++) i_data[k*DW +: DW] = mk_data(tag, k);
        #1;
        check("o_ready", 64'(o_ready), 64'(exp_rdy));
        check("o_valid", 64'(o_valid), 64'(exp_vld));
        if (exp_rdy != '0) begin
            w = first_set(exp_rdy);
            exp_q.push_back('{src: SW'(w), data: mk_data(tag, w)});
        end
        tag++;
    endtask

    // Reset with every requester active; nothing may be granted and the held
    // word, if any, is dropped.
    task automatic reset_pulse();
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = '1;
        i_ready = 1'b1;
        #1;
        check("rst_o_ready", 64'(o_ready), 64'h0);
        @(posedge i_clk);
        #1;
        check("rst_o_ready_after", 64'(o_ready), 64'h0);
        check("rst_o_valid", 64'(o_valid), 64'h0);
        check("rst_o_src", 64'(o_src), 64'h0);
        check("rst_o_data", 64'(o_data), 64'h0);
        exp_q.delete();
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = '0;
        i_ready = 1'b0;
    endtask

    // Monitor: a presented word must match the queue head every cycle it is
    // shown, and is retired only when the downstream accepts it.
    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_rst && o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(o_valid), 64'h0);
                end else begin
                    check("o_src", 64'(o_src), 64'(exp_q[0].src));
                    check("o_data", 64'(o_data), 64'(exp_q[0].data));
                    if (i_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0] cur_valid;
        int wait_cnt [N_REQ];
        int w;

        reset_pulse();

        // All requesters, downstream always ready: 0,1,2,3,0,1 back to back.
        step(4'b1111, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 1'b1, 4'b0010, 1'b1);
        step(4'b1111, 1'b1, 4'b0100, 1'b1);
        step(4'b1111, 1'b1, 4'b1000, 1'b1);
        step(4'b1111, 1'b1, 4'b0001, 1'b1);
        step(4'b1111, 1'b1, 4'b0010, 1'b1);
        // Stall five cycles holding src 1: no grants, word held steady.
        repeat (5) step(4'b1111, 1'b0, 4'b0000, 1'b1);
        // Drain with no requests, stay empty, then lone requester 1 (ptr=2).
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0010, 1'b0, 4'b0010, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        // Move ptr to 3, then lone requester 2 must be found across the wrap.
        step(4'b0100, 1'b0, 4'b0100, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0100, 1'b1, 4'b0100, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        // ptr=3: requester 3 wins over lower indices, ptr wraps to 0.
        step(4'b1111, 1'b1, 4'b1000, 1'b1);
        // ptr=0, only 1 active: grant 1, ptr becomes 2 with the slot full.
        step(4'b0010, 1'b1, 4'b0010, 1'b1);
        // Reset while full with ptr=2; first grant afterwards is index 0.
        reset_pulse();
        step(4'b1111, 1'b1, 4'b0001, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);

        // Random traffic: requesters hold valid until granted.
        cur_valid = '0;
        for (int k = 0; k < N_REQ; k++) wait_cnt[k] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge i_clk);
            for (int k = 0; k < N_REQ; k++) begin
                if (!cur_valid[k]) cur_valid[k] = ($urandom_range(0, 9) < 6);
                i_data[k*DW +: DW] = $urandom;
            end
            i_valid = cur_valid;
            i_ready = ($urandom_range(0, 9) < 7);
            #1;
            check("ready_onehot0", 64'($onehot0(o_ready)), 64'h1);
            check("ready_only_if_valid", 64'(o_ready & ~i_valid), 64'h0);
            if (o_ready != '0) begin
                w = first_set(o_ready);
                exp_q.push_back('{src: SW'(w), data: i_data[w*DW +: DW]});
                for (int k = 0; k < N_REQ; k++) begin
                    if (k != w && cur_valid[k]) begin
                        wait_cnt[k]++;
                        check("rr_wait_bound", 64'(wait_cnt[k] < N_REQ), 64'h1);
                    end
                end
                wait_cnt[w]  = 0;
                cur_valid[w] = 1'b0;
            end
        end

        @(negedge i_clk);
        i_valid = '0;
        i_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        #3;
        check("drain_queue_empty", 64'(exp_q.size()), 64'h0);
        check("drain_o_valid", 64'(o_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
